// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//   Shared pipeline types for every stage latch in the core.
//   pipe_state_t : per-stage control state driven by the hazard unit.
//   PIPE_NOP     : nop encoding bit; a nop payload is this bit replicated
//                  across the payload width (all zeros).
package cpu_types_pkg;

   typedef enum logic [1:0] {
      PIPE_NORMAL = 2'd0,
      PIPE_STALL  = 2'd1,
      PIPE_FLUSH  = 2'd2,
      PIPE_BUBBLE = 2'd3
   } pipe_state_t;

   localparam logic PIPE_NOP = 1'b0;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating up-counter used for stage performance statistics.
//   Ports:
//     CLK   in  clock, rising edge
//     RST   in  synchronous active-high reset, clears count
//     inc   in  increment request for this cycle
//     count out current value, sticks at all-ones
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] ONE = 1;

   always_ff @(posedge CLK) begin
      if (RST)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + ONE;
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Reusable pipeline stage register with hazard-unit control
//   (normal/stall/flush/bubble), a valid/ready handshake toward the next
//   stage and saturating stall/bubble counters.
//   Build option: PIPE_SKID_EN adds a one-entry skid buffer so in_ready
//   depends only on registered state (no combinational path from out_ready).
//   Ports:
//     CLK, RST            clock, synchronous active-high reset
//     state_i             stage control from the hazard unit
//     in_valid/in_ready   upstream handshake, in_data payload
//     out_valid/out_ready downstream handshake, out_data registered payload
//     stall_cnt           cycles spent in PIPE_STALL (saturating)
//     bubble_cnt          nops emitted by PIPE_BUBBLE (saturating)
module pipe_stage_reg
   import cpu_types_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  pipe_state_t       state_i,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam logic [DATA_W-1:0] NOP_DATA = {DATA_W{PIPE_NOP}};

   logic              load;      // output register may take a new value
   logic              accept;    // upstream transfer this cycle
   logic              advance;   // state that lets the output register load
   logic              skid_valid;
   logic              src_valid;
   logic [DATA_W-1:0] src_data;

   assign load    = out_ready || !out_valid;
   assign advance = (state_i == PIPE_NORMAL) || (state_i == PIPE_BUBBLE);
   assign accept  = in_valid && in_ready;

`ifdef PIPE_SKID_EN
   logic [DATA_W-1:0] skid_data;

   assign in_ready = (state_i == PIPE_NORMAL) && !skid_valid;

   // Skid fills only when a payload is accepted while the output is blocked;
   // it empties on the first cycle the output can take it.
   always_ff @(posedge CLK) begin
      if (RST || (state_i == PIPE_FLUSH)) begin
         skid_valid <= 1'b0;
         skid_data  <= NOP_DATA;
      end else if (advance && load && skid_valid) begin
         skid_valid <= 1'b0;
      end else if (accept && !load) begin
         skid_valid <= 1'b1;
         skid_data  <= in_data;
      end
   end
`else
   assign skid_valid = 1'b0;
   assign in_ready   = (state_i == PIPE_NORMAL) && load;
`endif

   // Next output value: a pending skid entry wins, then an accepted input,
   // otherwise a nop (covers both an idle NORMAL cycle and a BUBBLE).
   always_comb begin
      src_valid = accept;
      src_data  = accept ? in_data : NOP_DATA;
`ifdef PIPE_SKID_EN
      if (skid_valid) begin
         src_valid = 1'b1;
         src_data  = skid_data;
      end
`endif
   end

   always_ff @(posedge CLK) begin
      if (RST || (state_i == PIPE_FLUSH)) begin
         out_valid <= 1'b0;
         out_data  <= NOP_DATA;
      end else if (advance && load) begin
         out_valid <= src_valid;
         out_data  <= src_data;
      end
   end

   // A bubble only counts when the nop actually reaches the output register.
   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (state_i == PIPE_STALL),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .inc   ((state_i == PIPE_BUBBLE) && load && !skid_valid),
      .count (bubble_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
   import cpu_types_pkg::*;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 2;

   logic              clk = 1'b0;
   logic              rst;
   pipe_state_t       state_i;
   logic              in_valid, in_ready, out_valid, out_ready;
   logic [DATA_W-1:0] in_data, out_data;
   logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   logic [DATA_W-1:0] sb[$];

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .CLK(clk), .RST(rst), .state_i(state_i),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: a payload is consumed at the coming edge when it is presented,
   // downstream is ready and the stage is not stalled.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready && state_i != PIPE_STALL) begin
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_extra: got 0x%0h expected no payload", out_data);
         end else begin
            n_tests--;
            chk("sb_data", out_data, sb.pop_front());
         end
      end
   end

   initial begin
      int idx;
      logic acc;
      // reset with junk on the input
      rst = 1; state_i = PIPE_NORMAL; in_valid = 1; in_data = 32'hDEADBEEF; out_ready = 1;
      tick(); tick();
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_stall_cnt", {30'b0, stall_cnt}, 0);
      chk("rst_bubble_cnt", {30'b0, bubble_cnt}, 0);
      rst = 0; in_valid = 0;
      tick();

      // streaming 1,2,3 back to back
      for (int v = 1; v <= 3; v++) begin
         in_valid = 1; in_data = v; sb.push_back(v);
         #1 chk("stream_in_ready", {31'b0, in_ready}, 1);
         tick();
         chk("stream_out_valid", {31'b0, out_valid}, 1);
         chk("stream_out_data", out_data, v);
      end
      in_valid = 0;
      tick();

      // stall holds 0x10 for 3 cycles
      in_valid = 1; in_data = 32'h10; sb.push_back(32'h10);
      tick();
      state_i = PIPE_STALL; in_data = 32'h99;
      #1 chk("stall_in_ready", {31'b0, in_ready}, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_hold", out_data, 32'h10);
      end
      chk("stall_cnt3", {30'b0, stall_cnt}, 3);
      state_i = PIPE_NORMAL; in_valid = 0;
      tick();
      state_i = PIPE_STALL;
      tick(); tick();
      chk("stall_cnt_sat", {30'b0, stall_cnt}, 3);
      state_i = PIPE_NORMAL;

      // flush: 0x55 is never consumed (out_ready low), so it is not expected
      in_valid = 1; in_data = 32'h55; out_ready = 0;
      tick();
      chk("flush_pre_valid", {31'b0, out_valid}, 1);
      state_i = PIPE_FLUSH; in_data = 32'h66;
      #1 chk("flush_in_ready", {31'b0, in_ready}, 0);
      tick();
      chk("flush_out_valid", {31'b0, out_valid}, 0);
      chk("flush_out_data", out_data, 0);
      state_i = PIPE_NORMAL; in_valid = 0; out_ready = 1;
      tick();
      chk("flush_dropped", {31'b0, out_valid}, 0);

      // bubble then the held payload
      state_i = PIPE_BUBBLE; in_valid = 1; in_data = 32'h77;
      #1 chk("bubble_in_ready", {31'b0, in_ready}, 0);
      tick();
      chk("bubble_nop_valid", {31'b0, out_valid}, 0);
      chk("bubble_nop_data", out_data, 0);
      chk("bubble_cnt1", {30'b0, bubble_cnt}, 1);
      state_i = PIPE_NORMAL; sb.push_back(32'h77);
      tick();
      chk("bubble_next", out_data, 32'h77);
      in_valid = 0;
      tick();

      // bubble blocked by out_ready=0: holds, not counted
      in_valid = 1; in_data = 32'h88; sb.push_back(32'h88);
      tick();
      in_valid = 0; out_ready = 0; state_i = PIPE_BUBBLE;
      tick();
      chk("bubble_blk_data", out_data, 32'h88);
      chk("bubble_blk_cnt", {30'b0, bubble_cnt}, 1);
      state_i = PIPE_NORMAL;
      // backpressure: only the skid build still accepts here
      #1;
`ifdef PIPE_SKID_EN
      chk("bp_in_ready", {31'b0, in_ready}, 1);
`else
      chk("bp_in_ready", {31'b0, in_ready}, 0);
`endif
      out_ready = 1;
      tick();
      state_i = PIPE_BUBBLE;
      for (int i = 0; i < 3; i++) tick();
      chk("bubble_cnt_sat", {30'b0, bubble_cnt}, 3);
      state_i = PIPE_NORMAL;

      // 4-word burst with one cycle of downstream backpressure
      idx = 0;
      for (int c = 0; c < 10; c++) begin
         out_ready = (c != 2);
         in_valid  = (idx < 4);
         in_data   = 32'hA0 + idx;
         #1 acc = in_valid && in_ready;
         if (acc) begin
            sb.push_back(32'hA0 + idx);
            idx++;
         end
         tick();
      end
      in_valid = 0; out_ready = 1;
      tick(); tick();
      chk("burst_accepted", idx, 4);
      chk("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
